mux_8bit_32to1: RTL and testbench
=================================

# mux_8bit_32to1

Registered 8-bit, 32-to-1 multiplexer. A 5-bit select picks one of 32 byte-wide data inputs, and the chosen byte is captured into an output register on each rising clock edge. It sits between a bank of byte sources (register file or table constants) and a single downstream byte consumer that needs a glitch-free, clock-aligned value.

## Interface
- Parameters: none. Data width is fixed at 8 bits and input count at 32.
- Port order for positional instantiation: clk, rst, select, i0 … i31, out_signal, then out_parity when enabled.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- select  input  5  index of the input to route (0–31).
- i0 … i31  input  8 each  data inputs; ix is chosen when select == x.
- out_signal  output  8  registered selected byte.
- out_parity  output  1  only with MUX8_PARITY_EN; registered even-parity bit of out_signal.

## Operation
- Combinational stage: sel_byte = i[select], a full 32-way decode.
  - All 32 select codes are legal; no default or out-of-range case exists.
  - The decode must not infer latches.
- Register stage: out_signal <= sel_byte on every rising clk edge while rst is low.
  - No enable; the register loads every cycle.
- Reset: while rst is high, out_signal = 8'h00 and out_parity = 0, regardless of clk, select or data.
- Data inputs and select are sampled only at the clock edge.
  - Changes between edges have no effect on outputs until the next edge.
- Simultaneous change of select and data before an edge: the register captures the new data at the new select.
- Duplicate input values, e.g. two inputs both 130, are passed unchanged. There is no priority logic.
- Any X on select propagates to out_signal; no X-masking is required.

## Timing
- Latency is 1 clock. A select or data value present at rising edge N appears on out_signal after edge N, and holds until edge N+1.
- Throughput is one new selection per cycle.
- Reset assertion clears outputs immediately, not at the next edge.
- Reset deassertion: the first load occurs at the first rising edge with rst low.
  - rst must be released synchronously to clk (standard reset synchronizer upstream).
- Reset mid-stream: the current registered value is lost and the outputs are 0 until the first post-release edge.
- The combinational path select/ix → register D must meet one clk period. Budget about 5 levels of 2:1 mux.

## Configuration
- MUX8_PARITY_EN defined:
  - Adds the out_parity output, registered alongside out_signal.
  - out_parity = XOR of the 8 selected bits (1 when the byte has an odd number of ones).
  - Same 1-cycle latency and reset value 0.
- MUX8_PARITY_EN undefined: the out_parity port and its flop are absent; all other behaviour is identical.

## Test plan
- Reset: drive rst=1 with select=5 and i5=50 → out_signal=0x00 (and out_parity=0) immediately; it stays 0 across clock edges while rst is high.
- Full sweep: set i0=69, i1=10, … i25=250, i26=216, i27=217, i28=218, i29=219, i30=130, i31=131. Step select 0→31, one per cycle → out_signal equals the matching ix one cycle after each edge (69, 10, …, 130, 131).
- Latency check: change select from 0 to 31 mid-cycle → out_signal stays 69 until the next rising edge, then becomes 131.
- Asynchronous reset mid-sweep: assert rst between edges while out_signal=200 → out_signal=0 without waiting for an edge. Release rst with select=3 and i3=30 → out_signal=30 after the first post-release edge.
- Boundary codes: select=0 with i0=0xFF, then select=31 with i31=0x00 → 0xFF then 0x00. Changing a non-selected input, e.g. i15=0xAA, leaves out_signal unchanged.
- With MUX8_PARITY_EN: select byte 69 (0x45, three ones) → out_parity=1. Select byte 30 (0x1E, four ones) → out_parity=0. Both values align with out_signal on the same cycle.

Source files
------------

// File: rtl/mux_8bit_32to1.sv
// Registered 8-bit 32:1 mux, 1-cycle latency, loads every cycle (no backpressure).
// Define MUX8_PARITY_EN to add the registered even-parity output out_parity.
module mux_8bit_32to1 (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] select,
  input  logic [7:0] i0,
  input  logic [7:0] i1,
  input  logic [7:0] i2,
  input  logic [7:0] i3,
  input  logic [7:0] i4,
  input  logic [7:0] i5,
  input  logic [7:0] i6,
  input  logic [7:0] i7,
  input  logic [7:0] i8,
  input  logic [7:0] i9,
  input  logic [7:0] i10,
  input  logic [7:0] i11,
  input  logic [7:0] i12,
  input  logic [7:0] i13,
  input  logic [7:0] i14,
  input  logic [7:0] i15,
  input  logic [7:0] i16,
  input  logic [7:0] i17,
  input  logic [7:0] i18,
  input  logic [7:0] i19,
  input  logic [7:0] i20,
  input  logic [7:0] i21,
  input  logic [7:0] i22,
  input  logic [7:0] i23,
  input  logic [7:0] i24,
  input  logic [7:0] i25,
  input  logic [7:0] i26,
  input  logic [7:0] i27,
  input  logic [7:0] i28,
  input  logic [7:0] i29,
  input  logic [7:0] i30,
  input  logic [7:0] i31,
  output logic [7:0] out_signal
`ifdef MUX8_PARITY_EN
  ,
  output logic       out_parity
`endif
);

  logic [7:0] in_arr [32];
  logic [7:0] sel_byte_d;
  logic [7:0] out_signal_q;

  assign in_arr[0]  = i0;
  assign in_arr[1]  = i1;
  assign in_arr[2]  = i2;
  assign in_arr[3]  = i3;
  assign in_arr[4]  = i4;
  assign in_arr[5]  = i5;
  assign in_arr[6]  = i6;
  assign in_arr[7]  = i7;
  assign in_arr[8]  = i8;
  assign in_arr[9]  = i9;
  assign in_arr[10] = i10;
  assign in_arr[11] = i11;
  assign in_arr[12] = i12;
  assign in_arr[13] = i13;
  assign in_arr[14] = i14;
  assign in_arr[15] = i15;
  assign in_arr[16] = i16;
  assign in_arr[17] = i17;
  assign in_arr[18] = i18;
  assign in_arr[19] = i19;
  assign in_arr[20] = i20;
  assign in_arr[21] = i21;
  assign in_arr[22] = i22;
  assign in_arr[23] = i23;
  assign in_arr[24] = i24;
  assign in_arr[25] = i25;
  assign in_arr[26] = i26;
  assign in_arr[27] = i27;
  assign in_arr[28] = i28;
  assign in_arr[29] = i29;
  assign in_arr[30] = i30;
  assign in_arr[31] = i31;

  // Every 5-bit code indexes a real input, so the decode is total and latch-free.
  always_comb begin
    sel_byte_d = in_arr[select];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_signal_q <= 8'h00;
    end else begin
      out_signal_q <= sel_byte_d;
    end
  end

  assign out_signal = out_signal_q;

`ifdef MUX8_PARITY_EN
  logic parity_d;
  logic parity_q;

  // Computed from D so the parity flop stays aligned with out_signal.
  assign parity_d = ^sel_byte_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_8bit_32to1.sv
// Directed bench for mux_8bit_32to1 with an expected-value queue.
module tb_mux_8bit_32to1;

  logic       clk;
  logic       rst;
  logic [4:0] select;
  logic [7:0] d [32];
  logic [7:0] out_signal;
`ifdef MUX8_PARITY_EN
  logic       out_parity;
`endif

  logic [7:0] exp_q [$];
  int         pass_cnt;
  int         total_cnt;

  mux_8bit_32to1 dut (
    .clk(clk), .rst(rst), .select(select),
    .i0(d[0]),   .i1(d[1]),   .i2(d[2]),   .i3(d[3]),
    .i4(d[4]),   .i5(d[5]),   .i6(d[6]),   .i7(d[7]),
    .i8(d[8]),   .i9(d[9]),   .i10(d[10]), .i11(d[11]),
    .i12(d[12]), .i13(d[13]), .i14(d[14]), .i15(d[15]),
    .i16(d[16]), .i17(d[17]), .i18(d[18]), .i19(d[19]),
    .i20(d[20]), .i21(d[21]), .i22(d[22]), .i23(d[23]),
    .i24(d[24]), .i25(d[25]), .i26(d[26]), .i27(d[27]),
    .i28(d[28]), .i29(d[29]), .i30(d[30]), .i31(d[31]),
    .out_signal(out_signal)
`ifdef MUX8_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
  endtask

  task automatic chk_par(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s parity: observed %0b expected %0b", tag, obs, exp);
  endtask

  // Zero output and zero parity expected.
  task automatic chk_zero(input string tag);
    chk(tag, out_signal, 8'h00);
`ifdef MUX8_PARITY_EN
    chk_par(tag, out_parity, 1'b0);
`endif
  endtask

  // Pop the next expected byte and compare it (and its parity) against the outputs.
  task automatic sb_check(input string tag);
    logic [7:0] exp;
    if (exp_q.size() == 0) begin
      total_cnt++;
      $error("FAIL %s: observed 0x%02h expected <scoreboard empty>", tag, out_signal);
    end else begin
      exp = exp_q.pop_front();
      chk(tag, out_signal, exp);
`ifdef MUX8_PARITY_EN
      chk_par(tag, out_parity, ^exp);
`endif
    end
  endtask

  // Drive select on the falling edge, then check one edge later.
  task automatic step(input logic [4:0] s, input string tag);
    @(negedge clk);
    select = s;
    exp_q.push_back(d[s]);
    @(posedge clk);
    #1;
    sb_check(tag);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b0;
    select    = 5'd5;
    for (int i = 0; i < 32; i++) d[i] = 8'd0;
    d[5] = 8'd50;

    // Reset clears immediately and holds across edges.
    #2 rst = 1'b1;
    #1 chk_zero("reset_immediate");
    @(posedge clk); #1 chk_zero("reset_hold_edge1");
    @(posedge clk); #1 chk_zero("reset_hold_edge2");

    d[0] = 8'd69;
    for (int i = 1; i <= 25; i++) d[i] = 8'(i * 10);
    d[26] = 8'd216; d[27] = 8'd217; d[28] = 8'd218; d[29] = 8'd219;
    d[30] = 8'd130; d[31] = 8'd131;

    @(negedge clk);
    rst = 1'b0;

    // Full sweep of all 32 select codes.
    for (int s = 0; s < 32; s++) step(5'(s), $sformatf("sweep_sel%0d", s));

    // Mid-cycle select change has no effect until the next edge.
    step(5'd0, "latency_sel0");
    #3;
    select = 5'd31;
    exp_q.push_back(d[31]);
    #2 chk("latency_hold", out_signal, 8'd69);
    @(posedge clk); #1 sb_check("latency_sel31");

    // Asynchronous reset between edges while holding 200.
    step(5'd20, "pre_reset_200");
    #2 rst = 1'b1;
    #1 chk_zero("async_reset_midcycle");
    @(posedge clk); #1 chk_zero("async_reset_hold");
    @(negedge clk);
    rst    = 1'b0;
    select = 5'd3;
    exp_q.push_back(d[3]);
    @(posedge clk); #1 sb_check("post_release_sel3");

    // Boundary codes with extreme data.
    d[0] = 8'hFF;
    step(5'd0, "boundary_sel0_ff");
    d[31] = 8'h00;
    step(5'd31, "boundary_sel31_00");

    // Non-selected input change leaves output alone.
    @(negedge clk);
    d[15] = 8'hAA;
    exp_q.push_back(8'h00);
    @(posedge clk); #1 sb_check("nonselected_i15");

    // Simultaneous select and data change captures the new pair.
    @(negedge clk);
    d[9]   = 8'h5A;
    select = 5'd9;
    exp_q.push_back(8'h5A);
    @(posedge clk); #1 sb_check("simultaneous_sel9");

    // Duplicate values pass through without priority effects.
    d[7] = 8'd130;
    step(5'd7, "duplicate_i7");
    step(5'd30, "duplicate_i30");

    // Parity-focused bytes: 0x45 (odd ones) and 0x1E (even ones).
    d[2] = 8'h45;
    step(5'd2, "parity_odd_45");
    step(5'd3, "parity_even_1e");

    if (exp_q.size() != 0) begin
      total_cnt++;
      $error("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
